// File: rtl/pong_ball_engine_if.sv
// Pixel-counter inputs and draw/game-state outputs of the pong ball engine.
// The engine uses the slave modport; the counter/colour side uses the master modport.
interface pong_ball_engine_if;
  logic [9:0] i_col;
  logic [9:0] i_row;
  logic       i_hsync;
  logic       i_vsync;
  logic       i_start;
  logic [9:0] i_paddle_y;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_draw_ball;
  logic       o_draw_paddle;
  logic [9:0] o_ball_x;
  logic [9:0] o_ball_y;
  logic [1:0] o_state;
  logic       o_miss;

  modport slave (
    input  i_col, i_row, i_hsync, i_vsync, i_start, i_paddle_y,
    output o_hsync, o_vsync, o_draw_ball, o_draw_paddle,
           o_ball_x, o_ball_y, o_state, o_miss
  );

  modport master (
    output i_col, i_row, i_hsync, i_vsync, i_start, i_paddle_y,
    input  o_hsync, o_vsync, o_draw_ball, o_draw_paddle,
           o_ball_x, o_ball_y, o_state, o_miss
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong ball/paddle engine: per-frame game update plus registered draw strobes.
// Define PONG_SPEEDUP_EN to make each paddle hit raise the ball speed up to MAX_SPEED.
module pong_ball_engine #(
  parameter int ACTIVE_COL   = 640,
  parameter int ACTIVE_ROW   = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_X     = 16,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int SERVE_FRAMES = 60,
  parameter int INIT_SPEED   = 2,
  parameter int MAX_SPEED    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  pong_ball_engine_if.slave vga
);

  localparam logic [10:0] X_MAX    = 11'(ACTIVE_COL - BALL_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(ACTIVE_ROW - BALL_SIZE);
  localparam logic [9:0]  X_CTR    = 10'((ACTIVE_COL - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR    = 10'((ACTIVE_ROW - BALL_SIZE) / 2);
  localparam logic [10:0] PAD_X0   = 11'(PADDLE_X);
  localparam logic [10:0] PAD_EDGE = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] PAD_H    = 11'(PADDLE_H);
  localparam logic [9:0]  PAD_YMAX = 10'(ACTIVE_ROW - PADDLE_H);
  localparam logic [10:0] BALL_S   = 11'(BALL_SIZE);
  localparam logic [10:0] COL_N    = 11'(ACTIVE_COL);
  localparam logic [10:0] ROW_N    = 11'(ACTIVE_ROW);
  localparam logic [7:0]  SERVE_N  = 8'(SERVE_FRAMES);
  localparam logic [2:0]  SPD_MAX  = 3'(MAX_SPEED);
  localparam logic [2:0]  SPD_INIT = (INIT_SPEED > MAX_SPEED) ? SPD_MAX : 3'(INIT_SPEED);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, MISS = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [9:0]  ball_x, ball_x_nxt, ball_y, ball_y_nxt;
  logic        dx, dx_nxt, dy, dy_nxt;
  logic [7:0]  serve_cnt, serve_cnt_nxt;
  logic        miss, miss_nxt;
  logic [9:0]  paddle_y, row_prev;
  logic        tick;
  logic [10:0] spd, x_cur, y_cur, pad_cur, col_cur, row_cur, x_mv, y_mv;
  logic        dx_mv, dy_mv, lost;
  logic        in_ball, in_paddle;
  logic        hsync_p1, vsync_p1, draw_ball_p1, draw_paddle_p1;
`ifdef PONG_SPEEDUP_EN
  logic [2:0]  speed, speed_nxt, spd_mv;
`else
  localparam logic [2:0] speed = SPD_INIT;
`endif

  // First clk of vertical blanking
  assign tick    = (vga.i_row == 10'(ACTIVE_ROW)) && (row_prev != 10'(ACTIVE_ROW));
  assign spd     = {8'd0, speed};
  assign x_cur   = {1'b0, ball_x};
  assign y_cur   = {1'b0, ball_y};
  assign pad_cur = {1'b0, paddle_y};
  assign col_cur = {1'b0, vga.i_col};
  assign row_cur = {1'b0, vga.i_row};

  always_comb begin : move
    y_mv  = y_cur;
    dy_mv = dy;
    x_mv  = x_cur;
    dx_mv = dx;
    lost  = 1'b0;
`ifdef PONG_SPEEDUP_EN
    spd_mv = speed;
`endif
    if (dy) begin
      if (y_cur + spd >= Y_MAX) begin
        y_mv  = Y_MAX;
        dy_mv = 1'b0;
      end else begin
        y_mv  = y_cur + spd;
      end
    end else if (y_cur <= spd) begin
      y_mv  = 11'd0;
      dy_mv = 1'b1;
    end else begin
      y_mv  = y_cur - spd;
    end
    if (dx) begin
      if (x_cur + spd >= X_MAX) begin
        x_mv  = X_MAX;
        dx_mv = 1'b0;
      end else begin
        x_mv  = x_cur + spd;
      end
    end else if (x_cur <= PAD_EDGE + spd) begin
      // Paddle overlap judged on the pre-move row; a miss leaves x where it is
      if ((y_cur + BALL_S > pad_cur) && (y_cur < pad_cur + PAD_H)) begin
        x_mv  = PAD_EDGE;
        dx_mv = 1'b1;
`ifdef PONG_SPEEDUP_EN
        spd_mv = (speed < SPD_MAX) ? speed + 3'd1 : SPD_MAX;
`endif
      end else begin
        lost = 1'b1;
      end
    end else begin
      x_mv = x_cur - spd;
    end
  end

  always_comb begin : fsm
    state_nxt     = state;
    ball_x_nxt    = ball_x;
    ball_y_nxt    = ball_y;
    dx_nxt        = dx;
    dy_nxt        = dy;
    serve_cnt_nxt = serve_cnt;
    miss_nxt      = 1'b0;
`ifdef PONG_SPEEDUP_EN
    speed_nxt     = speed;
`endif
    case (state)
      IDLE: if (vga.i_start) begin
        state_nxt     = SERVE;
        serve_cnt_nxt = SERVE_N;
      end
      SERVE: if (tick) begin
        serve_cnt_nxt = serve_cnt - 8'd1;
        if (serve_cnt == 8'd1) state_nxt = PLAY;
      end
      PLAY: if (tick) begin
        ball_x_nxt = x_mv[9:0];
        ball_y_nxt = y_mv[9:0];
        dx_nxt     = dx_mv;
        dy_nxt     = dy_mv;
`ifdef PONG_SPEEDUP_EN
        speed_nxt  = spd_mv;
`endif
        if (lost) begin
          state_nxt = MISS;
          miss_nxt  = 1'b1;
        end
      end
      MISS: begin
        ball_x_nxt = X_CTR;
        ball_y_nxt = Y_CTR;
        dx_nxt     = 1'b1;
`ifdef PONG_SPEEDUP_EN
        speed_nxt  = SPD_INIT;
`endif
        if (tick) begin
          state_nxt     = SERVE;
          serve_cnt_nxt = SERVE_N;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ball_x    <= X_CTR;
      ball_y    <= Y_CTR;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_cnt <= 8'd0;
      miss      <= 1'b0;
      paddle_y  <= 10'd0;
      row_prev  <= 10'd0;
`ifdef PONG_SPEEDUP_EN
      speed     <= SPD_INIT;
`endif
    end else begin
      state     <= state_nxt;
      ball_x    <= ball_x_nxt;
      ball_y    <= ball_y_nxt;
      dx        <= dx_nxt;
      dy        <= dy_nxt;
      serve_cnt <= serve_cnt_nxt;
      miss      <= miss_nxt;
      row_prev  <= vga.i_row;
`ifdef PONG_SPEEDUP_EN
      speed     <= speed_nxt;
`endif
      if (tick) paddle_y <= (vga.i_paddle_y > PAD_YMAX) ? PAD_YMAX : vga.i_paddle_y;
    end
  end

  assign in_ball   = (state != MISS) &&
                     (col_cur >= x_cur) && (col_cur < x_cur + BALL_S) &&
                     (row_cur >= y_cur) && (row_cur < y_cur + BALL_S) &&
                     (col_cur < COL_N) && (row_cur < ROW_N);
  assign in_paddle = (col_cur >= PAD_X0) && (col_cur < PAD_EDGE) &&
                     (row_cur >= pad_cur) && (row_cur < pad_cur + PAD_H) &&
                     (col_cur < COL_N) && (row_cur < ROW_N);

  // Pixel stage p1: strobes and syncs leave together one clk after the counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_p1       <= 1'b1;
      vsync_p1       <= 1'b1;
      draw_ball_p1   <= 1'b0;
      draw_paddle_p1 <= 1'b0;
    end else begin
      hsync_p1       <= vga.i_hsync;
      vsync_p1       <= vga.i_vsync;
      draw_ball_p1   <= in_ball;
      draw_paddle_p1 <= in_paddle;
    end
  end

  assign vga.o_hsync       = hsync_p1;
  assign vga.o_vsync       = vsync_p1;
  assign vga.o_draw_ball   = draw_ball_p1;
  assign vga.o_draw_paddle = draw_paddle_p1;
  assign vga.o_ball_x      = ball_x;
  assign vga.o_ball_y      = ball_y;
  assign vga.o_state       = state;
  assign vga.o_miss        = miss;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: shortened frames, randomized pixels and
// paddle requests, compared against a frame-level game model of the ball rules.
module tb_pong_ball_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_ball_engine_if vga();

  pong_ball_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: ball box, directions, speed, state, latched paddle, serve count
  int mx, my, mdx, mdy, mspd, mst, mpad, mcnt;
  int hits = 0, misses = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1; mspd = 2; mst = 0; mpad = 0; mcnt = 0;
  endtask

  task automatic model_tick(input int py, output bit lost);
    int ny, ndy, nx, ndx;
    bit hit;
    lost = 1'b0;
    hit  = 1'b0;
    case (mst)
      1: begin
        if (mcnt == 1) mst = 2;
        mcnt--;
      end
      2: begin
        if (mdy == 1) begin
          if (my + mspd >= 472) begin ny = 472; ndy = 0; end
          else begin ny = my + mspd; ndy = 1; end
        end else if (my <= mspd) begin ny = 0; ndy = 1; end
        else begin ny = my - mspd; ndy = 0; end
        nx = mx; ndx = mdx;
        if (mdx == 1) begin
          if (mx + mspd >= 632) begin nx = 632; ndx = 0; end
          else nx = mx + mspd;
        end else if (mx <= 24 + mspd) begin
          if (my + 8 > mpad && my < mpad + 64) begin hit = 1'b1; nx = 24; ndx = 1; end
          else lost = 1'b1;
        end else nx = mx - mspd;
        mx = nx; my = ny; mdx = ndx; mdy = ndy;
        if (hit) begin
          hits++;
`ifdef PONG_SPEEDUP_EN
          if (mspd < 6) mspd++;
`endif
        end
        if (lost) begin
          misses++;
          mst = 3; mx = 316; my = 236; mdx = 1; mspd = 2;
        end
      end
      3: begin mst = 1; mcnt = 60; end
      default: ;
    endcase
    mpad = (py > 416) ? 416 : py;
  endtask

  function automatic bit exp_ball(input int c, input int r);
    return (mst != 3) && c >= mx && c < mx + 8 && r >= my && r < my + 8 && c < 640 && r < 480;
  endfunction

  function automatic bit exp_paddle(input int c, input int r);
    return c >= 16 && c < 24 && r >= mpad && r < mpad + 64 && c < 640 && r < 480;
  endfunction

  task automatic pix_at(input int c, input int r, input bit hs, input bit vs);
    @(negedge clk);
    vga.i_col = 10'(c); vga.i_row = 10'(r); vga.i_hsync = hs; vga.i_vsync = vs;
    @(posedge clk); #1;
    n_cmp++;
    if (vga.o_draw_ball !== exp_ball(c, r)) begin
      n_bad++;
      $display("FAIL draw_ball col=%0d row=%0d got %b want %b", c, r, vga.o_draw_ball, exp_ball(c, r));
    end
    n_cmp++;
    if (vga.o_draw_paddle !== exp_paddle(c, r)) begin
      n_bad++;
      $display("FAIL draw_paddle col=%0d row=%0d got %b want %b", c, r, vga.o_draw_paddle, exp_paddle(c, r));
    end
    n_cmp++;
    if (vga.o_hsync !== hs) begin
      n_bad++;
      $display("FAIL hsync_delay got %b want %b", vga.o_hsync, hs);
    end
    n_cmp++;
    if (vga.o_vsync !== vs) begin
      n_bad++;
      $display("FAIL vsync_delay got %b want %b", vga.o_vsync, vs);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic pix_check();
    int c, r;
    case ($urandom_range(0, 2))
      0: begin c = mx + int'($urandom_range(0, 9)) - 1; r = my + int'($urandom_range(0, 9)) - 1; end
      1: begin c = 16 + int'($urandom_range(0, 9)) - 1; r = mpad + int'($urandom_range(0, 65)) - 1; end
      default: begin c = int'($urandom_range(0, 1023)); r = int'($urandom_range(0, 1023)); end
    endcase
    if (c < 0) c = 0;
    if (r < 0) r = 0;
    if (r == 480) r = 481;
    pix_at(c, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_frame(input int py);
    bit lost;
    @(negedge clk);
    vga.i_paddle_y = 10'(py); vga.i_row = 10'd480; vga.i_col = 10'd0;
    @(posedge clk); #1;
    model_tick(py, lost);
    n_cmp++;
    if (vga.o_miss !== lost) begin
      n_bad++;
      $display("FAIL miss_pulse got %b want %b", vga.o_miss, lost);
    end
    n_cmp++;
    if (vga.o_state !== 2'(mst)) begin
      n_bad++;
      $display("FAIL state got %0d want %0d", vga.o_state, mst);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (vga.o_miss !== 1'b0) begin
      n_bad++;
      $display("FAIL miss_width got %b want 0", vga.o_miss);
    end
    n_cmp++;
    if (vga.o_ball_x !== 10'(mx)) begin
      n_bad++;
      $display("FAIL ball_x got %0d want %0d", vga.o_ball_x, mx);
    end
    n_cmp++;
    if (vga.o_ball_y !== 10'(my)) begin
      n_bad++;
      $display("FAIL ball_y got %0d want %0d", vga.o_ball_y, my);
    end
    @(negedge clk);
    vga.i_row = 10'd481;
    repeat (3) pix_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (vga.o_hsync !== 1'b1 || vga.o_vsync !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_sync got %b%b want 11", tag, vga.o_hsync, vga.o_vsync);
    end
    n_cmp++;
    if (vga.o_draw_ball !== 1'b0 || vga.o_draw_paddle !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_draw got %b%b want 00", tag, vga.o_draw_ball, vga.o_draw_paddle);
    end
    n_cmp++;
    if (vga.o_ball_x !== 10'd316 || vga.o_ball_y !== 10'd236) begin
      n_bad++;
      $display("FAIL %s_ball got (%0d,%0d) want (316,236)", tag, vga.o_ball_x, vga.o_ball_y);
    end
    n_cmp++;
    if (vga.o_state !== 2'd0 || vga.o_miss !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_state got %0d/%b want 0/0", tag, vga.o_state, vga.o_miss);
    end
  endtask

  task automatic test_reset();
    vga.i_col = 10'd100; vga.i_row = 10'd100; vga.i_hsync = 1'b0; vga.i_vsync = 1'b0;
    vga.i_start = 1'b0; vga.i_paddle_y = 10'd300;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    repeat (2) do_frame(int'($urandom_range(0, 1023)));
  endtask

  task automatic test_serve_play();
    pix_check();
    @(negedge clk);
    vga.i_start = 1'b1;
    @(posedge clk); #1;
    mst = 1; mcnt = 60;
    n_cmp++;
    if (vga.o_state !== 2'd1) begin
      n_bad++;
      $display("FAIL start_to_serve got %0d want 1", vga.o_state);
    end
    @(negedge clk);
    vga.i_start = 1'b0;
    repeat (60) do_frame(int'($urandom_range(0, 1023)));
    do_frame(200);
    n_cmp++;
    if (vga.o_ball_x !== 10'd318 || vga.o_ball_y !== 10'd238) begin
      n_bad++;
      $display("FAIL first_move got (%0d,%0d) want (318,238)", vga.o_ball_x, vga.o_ball_y);
    end
    @(negedge clk);
    vga.i_start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (vga.o_state !== 2'd2) begin
      n_bad++;
      $display("FAIL start_ignored got %0d want 2", vga.o_state);
    end
    @(negedge clk);
    vga.i_start = 1'b0;
  endtask

  task automatic test_play();
    int py, post;
    bit done;
    post = 0;
    done = 1'b0;
    for (int f = 0; f < 4000 && !done; f++) begin
      if (mdx == 0 && mx < 80) begin
        if (hits < 2) begin
          py = my - int'($urandom_range(4, 50));
          if (py < 0) py = 0;
        end else begin
          py = (my < 240) ? 416 : 0;
        end
      end else begin
        py = int'($urandom_range(0, 1023));
      end
      do_frame(py);
      if (misses > 0) post++;
      done = (post >= 70);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL play_timeout got hits=%0d misses=%0d want a miss after 2 hits", hits, misses);
    end
  endtask

  task automatic test_reset_midplay();
    pix_check();
    @(negedge clk);
    vga.i_col = 10'd333; vga.i_row = 10'd200; vga.i_hsync = 1'b0; vga.i_vsync = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midplay_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_frame(470);
    pix_at(16, 416, 1'b1, 1'b0);
    pix_at(23, 479, 1'b0, 1'b1);
    pix_at(20, 415, 1'b1, 1'b1);
    pix_at(24, 450, 1'b0, 1'b0);
    pix_at(20, 416, 1'b1, 1'b1);
    n_cmp++;
    if (vga.o_draw_paddle !== 1'b1) begin
      n_bad++;
      $display("FAIL paddle_clamp got %b want 1", vga.o_draw_paddle);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_serve_play();
    test_play();
    test_reset_midplay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
